fir_coef_ctrl: RTL and testbench
================================

FIR_COEF_CTRL -- requirements
Module: fir_coef_ctrl

Interface
REQ-001 The module SHALL have parameter NTAPS, default 23, meaning the number of FIR taps controlled.
REQ-002 The module SHALL have parameter WCOEFF, default 16, meaning the signed coefficient width (Q1.15 at default).
REQ-003 The module SHALL have port clk, input, 1 bit: the single clock for all logic.
REQ-004 The module SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 The module SHALL have port cfg_wr, input, 1 bit: write strobe into the shadow coefficient bank.
REQ-006 The module SHALL have port cfg_addr, input, $clog2(NTAPS) bits: tap index for the write.
REQ-007 The module SHALL have port cfg_data, input, signed WCOEFF bits: coefficient value for the write.
REQ-008 The module SHALL have port cfg_commit, input, 1 bit: request to make the shadow bank active.
REQ-009 The module SHALL have port smp_val, input, 1 bit: the FIR input-sample valid (d_in_val).
REQ-010 The module SHALL have port fir_val_i, input, 1 bit: raw FIR output valid.
REQ-011 The module SHALL have port coeffs, output, NTAPS x signed WCOEFF bits: active-bank coefficients driven to the FIR.
REQ-012 The module SHALL have port fir_val_o, output, 1 bit: FIR output valid after warm-up gating.
REQ-013 The module SHALL have port active_bank, output, 1 bit: index of the active bank (0/1).
REQ-014 The module SHALL have port busy, output, 1 bit: high while a commit is pending.
REQ-015 The module SHALL have port swap_done, output, 1 bit: one-cycle pulse on the edge where the banks swap.
REQ-016 The module SHALL have port cfg_err, output, 1 bit: one-cycle pulse for a rejected write or commit.

Function
REQ-017 Two banks SHALL exist, each holding NTAPS coefficients; coeffs SHALL be driven combinationally from the bank selected by active_bank.
REQ-018 The FSM SHALL have two states, IDLE and PEND.
REQ-019 In IDLE, cfg_wr with cfg_addr<NTAPS SHALL write cfg_data into the shadow bank (the bank not selected by active_bank) on that edge.
REQ-020 cfg_wr with cfg_addr>=NTAPS SHALL write nothing and SHALL pulse cfg_err on the following cycle.
REQ-021 cfg_commit in IDLE SHALL move the FSM to PEND on the next edge and SHALL assert busy from that cycle onward.
REQ-022 When cfg_wr and cfg_commit are asserted in the same IDLE cycle, the write SHALL be applied and the commit SHALL include it.
REQ-023 In PEND, the swap SHALL occur on the first edge where smp_val=0; on that edge active_bank SHALL toggle, the FSM SHALL return to IDLE, and swap_done SHALL pulse in the following cycle.
REQ-024 The swap SHALL never occur on an edge where smp_val=1, so coefficients never change under a sampled input.
REQ-025 In PEND, any cfg_wr or cfg_commit SHALL be ignored and SHALL pulse cfg_err on the following cycle.
REQ-026 After a swap, the new shadow bank SHALL retain its prior contents; there SHALL be no automatic copy between banks.
REQ-027 A saturating warm-up counter, range 0..NTAPS, SHALL increment on each smp_val.
REQ-028 fir_val_o SHALL equal fir_val_i AND (warm count == NTAPS), so the first output passed is the one for sample NTAPS.
REQ-029 A bank swap SHALL NOT reset the warm-up counter, because the delay line holds raw samples.

Reset
REQ-030 On rst, the FSM SHALL go to IDLE, active_bank to 0, busy, swap_done, cfg_err and fir_val_o to 0, and the warm count to 0.
REQ-031 On rst, bank 0 SHALL load the package default taps and bank 1 SHALL load zeros.
REQ-032 rst asserted while in PEND SHALL abandon the commit with no swap.

Structure
REQ-033 A package fir_ctrl_pkg SHALL hold the default 23-tap set (-374 -579 -822 -908 -693 -74 969 2343 3849 5215 6171 6514, mirrored), the state enum, and the coefficient-array typedef.
REQ-034 One sub-module, fir_warmup_gate (saturating counter plus valid gate), SHALL be instantiated.

Verification
REQ-035 The bench SHALL cover: release reset, then drive 30 smp_val pulses -> coeffs equal the default set, and fir_val_o stays 0 for samples 1-22 and passes sample 23 onward.
REQ-036 The bench SHALL cover: write addr 11=1000, then commit with smp_val=0 -> busy high 1 cycle, active_bank=1, coeffs[11]=1000 and all other taps 0, swap_done pulses once.
REQ-037 The bench SHALL cover: commit while smp_val is held high for 5 cycles -> the swap occurs on the first low cycle and not before.
REQ-038 The bench SHALL cover: write to addr 23, and a write during PEND -> cfg_err pulses each time, and the banks are unchanged.
REQ-039 The bench SHALL cover: simultaneous write (addr 0=-5) and commit -> the new active bank has coeffs[0]=-5.
REQ-040 The bench SHALL cover: rst during PEND -> active_bank=0, bank 0 holds the defaults, no swap_done pulse.

Source files
------------

// File: rtl/fir_ctrl_pkg.sv
// Shared types and default tap set for the FIR coefficient controller.
// Bank 0 is loaded with DEF_TAPS on reset.
package fir_ctrl_pkg;

   localparam int DEF_NTAPS  = 23;
   localparam int DEF_WCOEFF = 16;

   typedef enum logic {IDLE, PEND} state_t;

   typedef logic signed [DEF_WCOEFF-1:0] coef_t;
   typedef coef_t coef_arr_t [DEF_NTAPS];

   // Symmetric low-pass set in Q1.15; centre tap is index 11.
   localparam coef_arr_t DEF_TAPS = '{
      -16'sd374, -16'sd579, -16'sd822, -16'sd908, -16'sd693, -16'sd74,
       16'sd969,  16'sd2343, 16'sd3849, 16'sd5215, 16'sd6171, 16'sd6514,
       16'sd6171, 16'sd5215, 16'sd3849, 16'sd2343, 16'sd969,
      -16'sd74,  -16'sd693, -16'sd908, -16'sd822, -16'sd579, -16'sd374
   };

   function automatic coef_t def_tap(input int i);
      if (i >= 0 && i < DEF_NTAPS)
         return DEF_TAPS[i];
      else
         return '0;
   endfunction

endpackage

// File: rtl/fir_warmup_gate.sv
// Saturating count of input samples; FIR output valid is suppressed until
// the delay line has been filled with NTAPS real samples.
module fir_warmup_gate #(
   parameter int NTAPS = 23
) (
   input  logic clk,
   input  logic rst,
   input  logic smp_val,
   input  logic fir_val_i,
   output logic fir_val_o
);

   localparam int            CW   = $clog2(NTAPS + 1);
   localparam logic [CW-1:0] FULL = CW'(NTAPS);

   logic [CW-1:0] warm_cnt;

   always_ff @(posedge clk) begin
      if (rst)
         warm_cnt <= '0;
      else if (smp_val && (warm_cnt != FULL))
         warm_cnt <= warm_cnt + CW'(1);
   end

   assign fir_val_o = fir_val_i && (warm_cnt == FULL);

endmodule

// File: rtl/fir_coef_ctrl.sv
// Double-buffered FIR coefficient banks: writes land in the shadow bank and a
// commit swaps banks only on a cycle with no input sample.
module fir_coef_ctrl
   import fir_ctrl_pkg::*;
#(
   parameter int NTAPS  = 23,
   parameter int WCOEFF = 16
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       cfg_wr,
   input  logic [$clog2(NTAPS)-1:0]   cfg_addr,
   input  logic signed [WCOEFF-1:0]   cfg_data,
   input  logic                       cfg_commit,
   input  logic                       smp_val,
   input  logic                       fir_val_i,
   output logic signed [WCOEFF-1:0]   coeffs [NTAPS],
   output logic                       fir_val_o,
   output logic                       active_bank,
   output logic                       busy,
   output logic                       swap_done,
   output logic                       cfg_err
);

   localparam int           AW       = $clog2(NTAPS);
   localparam logic [AW:0]  ADDR_LIM = (AW+1)'(NTAPS);

   state_t state_q, state_d;
   logic   wr_en, swap, err_d, addr_ok;

   logic signed [WCOEFF-1:0] bank [2][NTAPS];

   assign addr_ok = ({1'b0, cfg_addr} < ADDR_LIM);
   assign busy    = (state_q == PEND);

   always_comb begin
      state_d = state_q;
      wr_en   = 1'b0;
      swap    = 1'b0;
      err_d   = 1'b0;
      case (state_q)
         IDLE: begin
            if (cfg_wr) begin
               if (addr_ok) wr_en = 1'b1;
               else         err_d = 1'b1;
            end
            if (cfg_commit) state_d = PEND;
         end
         PEND: begin
            err_d = cfg_wr | cfg_commit;
            // Never swap under a sampled input: wait for a gap in smp_val.
            if (!smp_val) begin
               swap    = 1'b1;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         active_bank <= 1'b0;
         swap_done   <= 1'b0;
         cfg_err     <= 1'b0;
      end else begin
         state_q   <= state_d;
         swap_done <= swap;
         cfg_err   <= err_d;
         if (swap) active_bank <= ~active_bank;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NTAPS; i++) begin
            bank[0][i] <= WCOEFF'(def_tap(i));
            bank[1][i] <= '0;
         end
      end else if (wr_en) begin
         bank[~active_bank][cfg_addr] <= cfg_data;
      end
   end

   always_comb begin
      for (int i = 0; i < NTAPS; i++)
         coeffs[i] = bank[active_bank][i];
   end

   fir_warmup_gate #(
      .NTAPS (NTAPS)
   ) u_warmup (
      .clk       (clk),
      .rst       (rst),
      .smp_val   (smp_val),
      .fir_val_i (fir_val_i),
      .fir_val_o (fir_val_o)
   );

endmodule

// File: tb/tb_fir_coef_ctrl.sv
// Directed bench for fir_coef_ctrl: reset, warm-up gating, commit/swap timing,
// rejected writes, write+commit in one cycle, and reset during a pending commit.
module tb_fir_coef_ctrl;

   logic              clk = 1'b0;
   logic              rst;
   logic              cfg_wr;
   logic [4:0]        cfg_addr;
   logic signed [15:0] cfg_data;
   logic              cfg_commit;
   logic              smp_val;
   logic              fir_val_i;
   logic signed [15:0] coeffs [23];
   logic              fir_val_o;
   logic              active_bank;
   logic              busy;
   logic              swap_done;
   logic              cfg_err;

   int n_chk  = 0;
   int n_pass = 0;

   int def_exp [23] = '{-374, -579, -822, -908, -693, -74, 969, 2343, 3849, 5215, 6171, 6514,
                        6171, 5215, 3849, 2343, 969, -74, -693, -908, -822, -579, -374};

   fir_coef_ctrl #(
      .NTAPS  (23),
      .WCOEFF (16)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .cfg_wr      (cfg_wr),
      .cfg_addr    (cfg_addr),
      .cfg_data    (cfg_data),
      .cfg_commit  (cfg_commit),
      .smp_val     (smp_val),
      .fir_val_i   (fir_val_i),
      .coeffs      (coeffs),
      .fir_val_o   (fir_val_o),
      .active_bank (active_bank),
      .busy        (busy),
      .swap_done   (swap_done),
      .cfg_err     (cfg_err)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input int got, input int exp);
      n_chk++;
      if (got == exp)
         n_pass++;
      else
         $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst        = 1'b1;
      cfg_wr     = 1'b0;
      cfg_addr   = '0;
      cfg_data   = '0;
      cfg_commit = 1'b0;
      smp_val    = 1'b0;
      fir_val_i  = 1'b0;
      tick();
      tick();
      rst = 1'b0;
      #1;

      // reset state
      check("rst_active", int'(active_bank), 0);
      check("rst_busy", int'(busy), 0);
      check("rst_swap_done", int'(swap_done), 0);
      check("rst_cfg_err", int'(cfg_err), 0);
      check("rst_fir_val_o", int'(fir_val_o), 0);
      for (int i = 0; i < 23; i++)
         check($sformatf("rst_tap%0d", i), int'(coeffs[i]), def_exp[i]);

      // warm-up: FIR output for sample k arrives one cycle after it
      for (int k = 1; k <= 31; k++) begin
         smp_val   = (k <= 30);
         fir_val_i = (k >= 2);
         #1;
         if (k >= 2)
            check($sformatf("warm_s%0d", k - 1), int'(fir_val_o), (k - 1 >= 23) ? 1 : 0);
         tick();
      end
      smp_val   = 1'b0;
      fir_val_i = 1'b0;

      // write tap 11 = 1000 into shadow, then commit with no sample
      cfg_wr = 1'b1; cfg_addr = 5'd11; cfg_data = 16'sd1000;
      tick();
      cfg_wr = 1'b0; cfg_commit = 1'b1;
      tick();
      cfg_commit = 1'b0;
      check("c1_busy_pend", int'(busy), 1);
      check("c1_active_pend", int'(active_bank), 0);
      check("c1_done_pend", int'(swap_done), 0);
      tick();
      check("c1_busy_after", int'(busy), 0);
      check("c1_active_after", int'(active_bank), 1);
      check("c1_swap_done", int'(swap_done), 1);
      for (int i = 0; i < 23; i++)
         check($sformatf("c1_tap%0d", i), int'(coeffs[i]), (i == 11) ? 1000 : 0);
      fir_val_i = 1'b1;
      #1;
      check("c1_warm_kept", int'(fir_val_o), 1);
      fir_val_i = 1'b0;
      tick();
      check("c1_swap_done_clr", int'(swap_done), 0);

      // commit while smp_val held high for 5 edges
      smp_val = 1'b1; cfg_commit = 1'b1;
      tick();
      cfg_commit = 1'b0;
      check("c2_busy0", int'(busy), 1);
      for (int c = 1; c < 5; c++) begin
         tick();
         check($sformatf("c2_hold_active%0d", c), int'(active_bank), 1);
         check($sformatf("c2_hold_done%0d", c), int'(swap_done), 0);
      end
      smp_val = 1'b0;
      tick();
      check("c2_active_swap", int'(active_bank), 0);
      check("c2_swap_done", int'(swap_done), 1);
      check("c2_busy_after", int'(busy), 0);
      check("c2_tap0_default", int'(coeffs[0]), -374);
      tick();

      // out-of-range write, then writes/commits while pending
      cfg_wr = 1'b1; cfg_addr = 5'd23; cfg_data = 16'sd777;
      tick();
      cfg_wr = 1'b0;
      check("e_addr23_err", int'(cfg_err), 1);
      tick();
      check("e_addr23_err_clr", int'(cfg_err), 0);
      smp_val = 1'b1; cfg_commit = 1'b1;
      tick();
      cfg_commit = 1'b0;
      check("e_commit_ok", int'(cfg_err), 0);
      check("e_busy", int'(busy), 1);
      cfg_wr = 1'b1; cfg_addr = 5'd5; cfg_data = 16'sd555;
      tick();
      cfg_wr = 1'b0;
      check("e_pend_wr_err", int'(cfg_err), 1);
      check("e_active_tap5", int'(coeffs[5]), -74);
      cfg_commit = 1'b1;
      tick();
      cfg_commit = 1'b0;
      check("e_pend_commit_err", int'(cfg_err), 1);
      tick();
      check("e_err_clr", int'(cfg_err), 0);
      smp_val = 1'b0;
      tick();
      check("e_active_swap", int'(active_bank), 1);
      check("e_tap11_kept", int'(coeffs[11]), 1000);
      check("e_tap5_unwritten", int'(coeffs[5]), 0);
      check("e_tap0_zero", int'(coeffs[0]), 0);
      check("e_tap22_zero", int'(coeffs[22]), 0);
      tick();

      // simultaneous write and commit
      cfg_wr = 1'b1; cfg_addr = 5'd0; cfg_data = -16'sd5; cfg_commit = 1'b1;
      tick();
      cfg_wr = 1'b0; cfg_commit = 1'b0;
      check("wc_busy", int'(busy), 1);
      check("wc_tap0_pend", int'(coeffs[0]), 0);
      tick();
      check("wc_active", int'(active_bank), 0);
      check("wc_tap0", int'(coeffs[0]), -5);
      check("wc_tap1", int'(coeffs[1]), -579);
      tick();

      // reset while a commit is pending
      smp_val = 1'b1; cfg_commit = 1'b1;
      tick();
      cfg_commit = 1'b0;
      check("r_busy_pend", int'(busy), 1);
      rst = 1'b1;
      tick();
      rst = 1'b0; smp_val = 1'b0;
      check("r_active", int'(active_bank), 0);
      check("r_busy", int'(busy), 0);
      check("r_swap_done", int'(swap_done), 0);
      for (int i = 0; i < 23; i++)
         check($sformatf("r_tap%0d", i), int'(coeffs[i]), def_exp[i]);
      fir_val_i = 1'b1;
      #1;
      check("r_warm_cleared", int'(fir_val_o), 0);
      fir_val_i = 1'b0;
      tick();
      check("r_no_swap_done", int'(swap_done), 0);
      check("r_active_hold", int'(active_bank), 0);
      check("r_busy_hold", int'(busy), 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
